// File: rtl/gps_acq_pkg.sv
// Shared types and widths for the GPS acquisition search controller.
package gps_acq_pkg;

  localparam int CODE_BIN_W = 11;
  localparam int DOPP_BIN_W = 5;
  localparam int MAG_W      = 20;

  typedef enum logic [2:0] {
    IDLE,
    DWELL,
    SLEW,
    SETTLE,
    VERIFY,
    LOCK,
    FAIL
  } acq_state_e;

  typedef struct packed {
    logic [MAG_W-1:0]      mag;
    logic [CODE_BIN_W-1:0] code;
    logic [DOPP_BIN_W-1:0] dopp;
  } peak_rec_t;

  // Only dumps taken while actively searching a bin contribute to the peak.
  function automatic logic is_peak_state(input acq_state_e s);
    return (s == DWELL) || (s == VERIFY);
  endfunction

endpackage

// File: rtl/acq_peak_hold.sv
// Holds the strongest correlation magnitude seen in the current search
// together with the code/Doppler bin where it occurred.
module acq_peak_hold
  import gps_acq_pkg::*;
(
  input  logic                  mclk,
  input  logic                  res,
  input  logic                  clear,
  input  logic                  update,
  input  logic [MAG_W-1:0]      integmag,
  input  logic [CODE_BIN_W-1:0] code_bin,
  input  logic [DOPP_BIN_W-1:0] dopp_bin,
  output logic [MAG_W-1:0]      peak_mag,
  output logic [CODE_BIN_W-1:0] peak_code,
  output logic [DOPP_BIN_W-1:0] peak_dopp
);

  peak_rec_t peak_d;
  peak_rec_t peak_q;

  // Strict greater-than so a later equal magnitude never displaces the first.
  always_comb begin
    peak_d = peak_q;
    if (clear) begin
      peak_d = '0;
    end else if (update && (integmag > peak_q.mag)) begin
      peak_d.mag  = integmag;
      peak_d.code = code_bin;
      peak_d.dopp = dopp_bin;
    end
  end

  // Peak record register.
  always_ff @(posedge mclk or negedge res) begin
    if (!res) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_mag  = peak_q.mag;
  assign peak_code = peak_q.code;
  assign peak_dopp = peak_q.dopp;

endmodule

// File: rtl/acq_search_ctrl.sv
// Serial code-phase / Doppler search sequencer. Steps through every
// half-chip code bin of every Doppler bin, verifies candidate hits, and
// reports lock or exhaustion of the search space.
module acq_search_ctrl
  import gps_acq_pkg::*;
#(
  parameter int NUM_CODE_BINS = 2046,
  parameter int NUM_DOPP_BINS = 21,
  parameter int VERIFY_DUMPS  = 8
) (
  input  logic                  mclk,
  input  logic                  res,
  input  logic                  start,
  input  logic                  aen,
  input  logic                  acq,
  input  logic                  acq8times,
  input  logic [MAG_W-1:0]      integmag,
  output logic                  code_slew,
  output logic                  car_change,
  output logic [CODE_BIN_W-1:0] code_bin,
  output logic [DOPP_BIN_W-1:0] dopp_bin,
  output logic                  locked,
  output logic                  search_fail,
  output logic [MAG_W-1:0]      peak_mag,
  output logic [CODE_BIN_W-1:0] peak_code,
  output logic [DOPP_BIN_W-1:0] peak_dopp
);

  localparam int VCNT_W = $clog2(VERIFY_DUMPS + 1);
  localparam logic [CODE_BIN_W-1:0] CODE_LAST  = CODE_BIN_W'(NUM_CODE_BINS - 1);
  localparam logic [DOPP_BIN_W-1:0] DOPP_LAST  = DOPP_BIN_W'(NUM_DOPP_BINS - 1);
  localparam logic [VCNT_W-1:0]     VERIFY_TGT = VCNT_W'(VERIFY_DUMPS);

  acq_state_e            state_q, state_d;
  logic                  aen_d_q;
  logic                  evt_d_q;
  logic                  dump_evt;
  logic [CODE_BIN_W-1:0] code_bin_q, code_bin_d;
  logic [DOPP_BIN_W-1:0] dopp_bin_q, dopp_bin_d;
  logic [VCNT_W-1:0]     vcnt_q, vcnt_d;
  logic                  slew_fail_q, slew_fail_d;
  logic                  code_slew_q, code_slew_d;
  logic                  car_change_q, car_change_d;
  logic                  locked_q, locked_d;
  logic                  search_fail_q, search_fail_d;
  logic                  enter_slew;
  logic                  peak_clear;
  logic                  peak_update;

  // A dump completes on the falling edge of aen; the comparator outputs are
  // valid one cycle later, which is when evt_d_q is consumed.
  assign dump_evt = aen_d_q & ~aen;

  // Next-state, bin counters and registered pulse outputs.
  always_comb begin
    state_d      = state_q;
    code_bin_d   = code_bin_q;
    dopp_bin_d   = dopp_bin_q;
    vcnt_d       = vcnt_q;
    slew_fail_d  = slew_fail_q;
    code_slew_d  = 1'b0;
    car_change_d = 1'b0;
    enter_slew   = 1'b0;
    peak_clear   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = DWELL;
          code_bin_d  = '0;
          dopp_bin_d  = '0;
          slew_fail_d = 1'b0;
          peak_clear  = 1'b1;
        end
      end
      DWELL: begin
        if (evt_d_q) begin
          if (acq) begin
            state_d = VERIFY;
            vcnt_d  = '0;
          end else begin
            enter_slew = 1'b1;
          end
        end
      end
      SLEW: begin
        state_d = slew_fail_q ? FAIL : SETTLE;
      end
      SETTLE: begin
        if (evt_d_q) begin
          state_d = DWELL;
        end
      end
      VERIFY: begin
        if (evt_d_q) begin
          if (acq8times) begin
            state_d = LOCK;
          end else if (!acq) begin
            enter_slew = 1'b1;
          end else begin
            vcnt_d = vcnt_q + VCNT_W'(1);
            if (vcnt_d == VERIFY_TGT) begin
              enter_slew = 1'b1;
            end
          end
        end
      end
      LOCK: begin
        if (evt_d_q && !acq) begin
          state_d = DWELL;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pulses are set on entry so they are high exactly during the SLEW cycle.
    // On exhaustion the code wraps but the carrier is left on the last bin.
    if (enter_slew) begin
      state_d     = SLEW;
      code_slew_d = 1'b1;
      slew_fail_d = 1'b0;
      if (code_bin_q == CODE_LAST) begin
        code_bin_d = '0;
        if (dopp_bin_q == DOPP_LAST) begin
          slew_fail_d = 1'b1;
        end else begin
          dopp_bin_d   = dopp_bin_q + DOPP_BIN_W'(1);
          car_change_d = 1'b1;
        end
      end else begin
        code_bin_d = code_bin_q + CODE_BIN_W'(1);
      end
    end

    // Dropping start wins over any dump or slew decided this cycle.
    if (!start) begin
      state_d      = IDLE;
      code_bin_d   = code_bin_q;
      dopp_bin_d   = dopp_bin_q;
      slew_fail_d  = slew_fail_q;
      code_slew_d  = 1'b0;
      car_change_d = 1'b0;
    end

    locked_d      = (state_d == LOCK);
    search_fail_d = (state_d == FAIL);
  end

  assign peak_update = evt_d_q && start && is_peak_state(state_q);

  // State machine, dump-edge detector and all registered outputs.
  always_ff @(posedge mclk or negedge res) begin
    if (!res) begin
      state_q       <= IDLE;
      aen_d_q       <= 1'b0;
      evt_d_q       <= 1'b0;
      code_bin_q    <= '0;
      dopp_bin_q    <= '0;
      vcnt_q        <= '0;
      slew_fail_q   <= 1'b0;
      code_slew_q   <= 1'b0;
      car_change_q  <= 1'b0;
      locked_q      <= 1'b0;
      search_fail_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      aen_d_q       <= aen;
      evt_d_q       <= dump_evt;
      code_bin_q    <= code_bin_d;
      dopp_bin_q    <= dopp_bin_d;
      vcnt_q        <= vcnt_d;
      slew_fail_q   <= slew_fail_d;
      code_slew_q   <= code_slew_d;
      car_change_q  <= car_change_d;
      locked_q      <= locked_d;
      search_fail_q <= search_fail_d;
    end
  end

  acq_peak_hold u_peak (
    .mclk      (mclk),
    .res       (res),
    .clear     (peak_clear),
    .update    (peak_update),
    .integmag  (integmag),
    .code_bin  (code_bin_q),
    .dopp_bin  (dopp_bin_q),
    .peak_mag  (peak_mag),
    .peak_code (peak_code),
    .peak_dopp (peak_dopp)
  );

  assign code_slew   = code_slew_q;
  assign car_change  = car_change_q;
  assign code_bin    = code_bin_q;
  assign dopp_bin    = dopp_bin_q;
  assign locked      = locked_q;
  assign search_fail = search_fail_q;

endmodule

// File: tb/tb_acq_search_ctrl.sv
// Scoreboard bench for acq_search_ctrl. Stimulus pushes expected slews,
// lock/fail flag changes and quiescent snapshots; a negedge monitor pops
// and compares them as the DUT presents each output.
module tb_acq_search_ctrl;

  // The Doppler range is shortened to six bins so the exhaustive sweep to
  // FAIL stays short; the code range keeps its full 2046 bins so the
  // 2045 -> 0 wrap is exercised at its real boundary.
  localparam int NCB = 2046;
  localparam int NDB = 6;
  localparam int VD  = 8;

  logic        mclk = 1'b0;
  logic        res = 1'b1;
  logic        start = 1'b0;
  logic        aen = 1'b0;
  logic        acq = 1'b0;
  logic        acq8times = 1'b0;
  logic [19:0] integmag = '0;
  logic        code_slew;
  logic        car_change;
  logic [10:0] code_bin;
  logic [4:0]  dopp_bin;
  logic        locked;
  logic        search_fail;
  logic [19:0] peak_mag;
  logic [10:0] peak_code;
  logic [4:0]  peak_dopp;

  acq_search_ctrl #(
    .NUM_CODE_BINS (NCB),
    .NUM_DOPP_BINS (NDB),
    .VERIFY_DUMPS  (VD)
  ) dut (
    .mclk        (mclk),
    .res         (res),
    .start       (start),
    .aen         (aen),
    .acq         (acq),
    .acq8times   (acq8times),
    .integmag    (integmag),
    .code_slew   (code_slew),
    .car_change  (car_change),
    .code_bin    (code_bin),
    .dopp_bin    (dopp_bin),
    .locked      (locked),
    .search_fail (search_fail),
    .peak_mag    (peak_mag),
    .peak_code   (peak_code),
    .peak_dopp   (peak_dopp)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic [10:0] code;
    logic [4:0]  dopp;
    logic        car;
  } slew_exp_t;

  typedef struct {
    logic        lck;
    logic        fl;
    logic [10:0] code;
    logic [4:0]  dopp;
  } flag_exp_t;

  typedef struct {
    string       name;
    logic [10:0] code;
    logic [4:0]  dopp;
    logic        lck;
    logic        fl;
    logic [19:0] pmag;
    logic [10:0] pcode;
    logic [4:0]  pdopp;
  } snap_exp_t;

  slew_exp_t slew_q[$];
  flag_exp_t flag_q[$];
  snap_exp_t snap_q[$];

  int checks = 0;
  int passes = 0;
  int mc = 0;
  int md = 0;

  slew_exp_t se;
  flag_exp_t fe;
  snap_exp_t sn;
  logic prev_locked = 1'b0;
  logic prev_fail = 1'b0;

  // Monitor: compare each DUT-presented event against the head of its queue.
  always @(negedge mclk) begin
    if (code_slew === 1'b1) begin
      checks++;
      if (slew_q.size() == 0) begin
        $display("[TB] FAIL slew: unexpected pulse got code=%0d dopp=%0d car=%0b, want none",
                 code_bin, dopp_bin, car_change);
      end else begin
        se = slew_q.pop_front();
        if (code_bin === se.code && dopp_bin === se.dopp && car_change === se.car) begin
          passes++;
        end else begin
          $display("[TB] FAIL slew: got code=%0d dopp=%0d car=%0b, want code=%0d dopp=%0d car=%0b",
                   code_bin, dopp_bin, car_change, se.code, se.dopp, se.car);
        end
      end
    end
    if (car_change === 1'b1 && code_slew !== 1'b1) begin
      checks++;
      $display("[TB] FAIL car_change_alone: got car_change=1 code_slew=%0b, want code_slew=1",
               code_slew);
    end
    if (locked !== prev_locked || search_fail !== prev_fail) begin
      checks++;
      if (flag_q.size() == 0) begin
        $display("[TB] FAIL flags: unexpected change got locked=%0b fail=%0b, want none",
                 locked, search_fail);
      end else begin
        fe = flag_q.pop_front();
        if (locked === fe.lck && search_fail === fe.fl && code_bin === fe.code && dopp_bin === fe.dopp) begin
          passes++;
        end else begin
          $display("[TB] FAIL flags: got locked=%0b fail=%0b code=%0d dopp=%0d, want locked=%0b fail=%0b code=%0d dopp=%0d",
                   locked, search_fail, code_bin, dopp_bin, fe.lck, fe.fl, fe.code, fe.dopp);
        end
      end
      prev_locked = locked;
      prev_fail   = search_fail;
    end
    if (snap_q.size() > 0) begin
      sn = snap_q.pop_front();
      checks++;
      if (code_slew === 1'b0 && car_change === 1'b0 && code_bin === sn.code &&
          dopp_bin === sn.dopp && locked === sn.lck && search_fail === sn.fl &&
          peak_mag === sn.pmag && peak_code === sn.pcode && peak_dopp === sn.pdopp) begin
        passes++;
      end else begin
        $display("[TB] FAIL %s: got slew=%0b car=%0b code=%0d dopp=%0d lock=%0b fail=%0b pmag=%0d pcode=%0d pdopp=%0d, want slew=0 car=0 code=%0d dopp=%0d lock=%0b fail=%0b pmag=%0d pcode=%0d pdopp=%0d",
                 sn.name, code_slew, car_change, code_bin, dopp_bin, locked, search_fail,
                 peak_mag, peak_code, peak_dopp, sn.code, sn.dopp, sn.lck, sn.fl,
                 sn.pmag, sn.pcode, sn.pdopp);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  // One dump: aen high for high_cycles, comparator outputs change as it falls.
  task automatic applyStimulus(input logic a, input logic a8, input logic [19:0] mag,
                               input int high_cycles);
    @(posedge mclk);
    #1;
    aen = 1'b1;
    repeat (high_cycles) @(posedge mclk);
    #1;
    aen       = 1'b0;
    acq       = a;
    acq8times = a8;
    integmag  = mag;
  endtask

  // Queue a quiescent snapshot for the monitor to compare at the next negedge.
  task automatic checkOutput(input string name, input logic [10:0] code, input logic [4:0] dopp,
                             input logic lck, input logic fl, input logic [19:0] pmag,
                             input logic [10:0] pcode, input logic [4:0] pdopp);
    snap_exp_t s;
    s.name  = name;
    s.code  = code;
    s.dopp  = dopp;
    s.lck   = lck;
    s.fl    = fl;
    s.pmag  = pmag;
    s.pcode = pcode;
    s.pdopp = pdopp;
    snap_q.push_back(s);
  endtask

  task automatic pushSlew(input logic [10:0] code, input logic [4:0] dopp, input logic car);
    slew_exp_t s;
    s.code = code;
    s.dopp = dopp;
    s.car  = car;
    slew_q.push_back(s);
  endtask

  task automatic pushFlags(input logic lck, input logic fl, input logic [10:0] code,
                           input logic [4:0] dopp);
    flag_exp_t f;
    f.lck  = lck;
    f.fl   = fl;
    f.code = code;
    f.dopp = dopp;
    flag_q.push_back(f);
  endtask

  // Expected bin step for one rejected bin, including wrap and exhaustion.
  task automatic advanceModel();
    if (mc == NCB - 1) begin
      mc = 0;
      if (md == NDB - 1) begin
        pushSlew(11'd0, 5'(md), 1'b0);
        pushFlags(1'b0, 1'b1, 11'd0, 5'(md));
      end else begin
        md = md + 1;
        pushSlew(11'd0, 5'(md), 1'b1);
      end
    end else begin
      mc = mc + 1;
      pushSlew(11'(mc), 5'(md), 1'b0);
    end
  endtask

  // Rejected bin: the dwell dump, then the straddling dump SETTLE discards.
  // The discarded dump carries a large magnitude that must not reach the peak.
  task automatic dwellMiss(input logic [19:0] mag, input int high_cycles);
    advanceModel();
    applyStimulus(1'b0, 1'b0, mag, high_cycles);
    applyStimulus(1'b0, 1'b0, 20'd900, 1);
  endtask

  initial begin
    bit seen;
    #2 res = 1'b0;
    checkOutput("reset", 11'd0, 5'd0, 1'b0, 1'b0, 20'd0, 11'd0, 5'd0);
    @(negedge mclk);
    @(posedge mclk);
    #1 res = 1'b1;
    idle(2);
    checkOutput("idle_no_start", 11'd0, 5'd0, 1'b0, 1'b0, 20'd0, 11'd0, 5'd0);

    @(posedge mclk);
    #1 start = 1'b1;
    idle(2);
    checkOutput("started", 11'd0, 5'd0, 1'b0, 1'b0, 20'd0, 11'd0, 5'd0);

    dwellMiss(20'd100, 1);
    dwellMiss(20'd300, 1);
    dwellMiss(20'd300, 1);
    idle(3);
    checkOutput("three_misses", 11'd3, 5'd0, 1'b0, 1'b0, 20'd300, 11'd1, 5'd0);

    dwellMiss(20'd200, 3);
    idle(3);
    checkOutput("long_aen_miss", 11'd4, 5'd0, 1'b0, 1'b0, 20'd300, 11'd1, 5'd0);

    applyStimulus(1'b1, 1'b0, 20'd50, 1);
    repeat (3) applyStimulus(1'b1, 1'b0, 20'd50, 1);
    pushFlags(1'b1, 1'b0, 11'd4, 5'd0);
    applyStimulus(1'b1, 1'b1, 20'd50, 1);
    applyStimulus(1'b1, 1'b0, 20'd50, 1);
    idle(3);
    checkOutput("lock_hold", 11'd4, 5'd0, 1'b1, 1'b0, 20'd300, 11'd1, 5'd0);
    pushFlags(1'b0, 1'b0, 11'd4, 5'd0);
    applyStimulus(1'b0, 1'b0, 20'd60, 1);
    idle(3);
    checkOutput("lock_lost", 11'd4, 5'd0, 1'b0, 1'b0, 20'd300, 11'd1, 5'd0);

    applyStimulus(1'b1, 1'b0, 20'd70, 1);
    repeat (VD - 1) applyStimulus(1'b1, 1'b0, 20'd70, 1);
    advanceModel();
    applyStimulus(1'b1, 1'b0, 20'd70, 1);
    applyStimulus(1'b0, 1'b0, 20'd900, 1);
    idle(3);
    checkOutput("verify_timeout", 11'd5, 5'd0, 1'b0, 1'b0, 20'd300, 11'd1, 5'd0);

    applyStimulus(1'b0, 1'b0, 20'd10, 1);
    @(posedge mclk);
    #1 start = 1'b0;
    idle(3);
    checkOutput("abort_over_slew", 11'd5, 5'd0, 1'b0, 1'b0, 20'd300, 11'd1, 5'd0);

    @(posedge mclk);
    #1 start = 1'b1;
    idle(2);
    checkOutput("restart", 11'd0, 5'd0, 1'b0, 1'b0, 20'd0, 11'd0, 5'd0);
    mc = 0;
    md = 0;

    for (int d = 0; d < NDB; d++) begin
      for (int c = 0; c < NCB; c++) begin
        dwellMiss(20'd0, 1);
      end
    end
    idle(3);
    checkOutput("exhausted", 11'd0, 5'd5, 1'b0, 1'b1, 20'd0, 11'd0, 5'd0);
    applyStimulus(1'b1, 1'b1, 20'd5, 1);
    idle(3);
    checkOutput("fail_hold", 11'd0, 5'd5, 1'b0, 1'b1, 20'd0, 11'd0, 5'd0);
    pushFlags(1'b0, 1'b0, 11'd0, 5'd5);
    @(posedge mclk);
    #1 start = 1'b0;
    idle(2);
    checkOutput("fail_to_idle", 11'd0, 5'd5, 1'b0, 1'b0, 20'd0, 11'd0, 5'd0);

    @(posedge mclk);
    #1 start = 1'b1;
    idle(2);
    applyStimulus(1'b0, 1'b0, 20'd77, 1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!seen) begin
        @(posedge mclk);
        #1;
        if (code_slew === 1'b1) seen = 1'b1;
      end
    end
    checks++;
    if (seen) passes++;
    else $display("[TB] FAIL slew_before_reset: got no code_slew within 8 cycles, want one");
    res = 1'b0;
    checkOutput("reset_mid_slew", 11'd0, 5'd0, 1'b0, 1'b0, 20'd0, 11'd0, 5'd0);
    @(negedge mclk);
    #1;

    checks++;
    if (slew_q.size() == 0) passes++;
    else $display("[TB] FAIL slew_drain: got %0d pending slews, want 0", slew_q.size());
    checks++;
    if (flag_q.size() == 0) passes++;
    else $display("[TB] FAIL flag_drain: got %0d pending flag changes, want 0", flag_q.size());
    checks++;
    if (snap_q.size() == 0) passes++;
    else $display("[TB] FAIL snap_drain: got %0d pending snapshots, want 0", snap_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion by time limit, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
